reset_seq: RTL and testbench

RESET_SEQ -- requirements
Module: reset_seq

---
 rtl/reset_seq.sv | 114 +++++++++++
 tb/tb_reset_seq.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/reset_seq.sv
// Reset sequencer: synchronizes rstb release, holds all channels in reset,
// then releases them one by one in ascending order with a fixed gap.
//
// state   | meaning
// RESET   | waiting for synchronized release, all channels held
// HOLD    | hold timer running, all channels held
// RELEASE | gap timer running between successive channel releases
// DONE    | every channel released
module reset_seq #(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_CH      = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int GAP_CYCLES  = 4
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              sw_rst,
  output logic [NUM_CH-1:0] ch_rstb,
  output logic              done,
  output logic              busy
);

  typedef enum logic [1:0] {RESET, HOLD, RELEASE, DONE} state_t;

  localparam logic [7:0] HOLD_LD = 8'(HOLD_CYCLES);
  localparam logic [7:0] GAP_LD  = 8'(GAP_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rel;
  state_t                 state_q, state_d;
  logic [7:0]             hold_q, hold_d;
  logic [7:0]             gap_q, gap_d;
  logic [NUM_CH-1:0]      ch_d;
  logic [NUM_CH-1:0]      ch_shift;
  logic                   done_d;
  logic                   do_rel;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
  end

  assign rel      = sync_q[SYNC_STAGES-1];
  assign ch_shift = (ch_rstb << 1) | NUM_CH'(1);

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    gap_d   = gap_q;
    ch_d    = ch_rstb;
    done_d  = done;
    do_rel  = 1'b0;
    case (state_q)
      // The edge on which rel is first seen already counts as the first hold edge.
      RESET: begin
        if (rel) begin
          if (HOLD_LD == 8'd1) begin
            do_rel = 1'b1;
          end else begin
            state_d = HOLD;
            hold_d  = HOLD_LD - 8'd1;
          end
        end
      end
      HOLD: begin
        if (hold_q <= 8'd1) do_rel = 1'b1;
        else                hold_d = hold_q - 8'd1;
      end
      RELEASE: begin
        if (gap_q <= 8'd1) do_rel = 1'b1;
        else               gap_d  = gap_q - 8'd1;
      end
      default: ;
    endcase
    if (do_rel) begin
      ch_d   = ch_shift;
      hold_d = '0;
      if (&ch_shift) begin
        state_d = DONE;
        done_d  = 1'b1;
        gap_d   = '0;
      end else begin
        state_d = RELEASE;
        gap_d   = GAP_LD;
      end
    end
    if (sw_rst && state_q != RESET) begin
      state_d = HOLD;
      hold_d  = HOLD_LD;
      gap_d   = '0;
      ch_d    = '0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= RESET;
      hold_q  <= '0;
      gap_q   <= '0;
      ch_rstb <= '0;
      done    <= 1'b0;
      busy    <= 1'b1;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      gap_q   <= gap_d;
      ch_rstb <= ch_d;
      done    <= done_d;
      busy    <= ~done_d;
    end
  end

endmodule

// File: tb/tb_reset_seq.sv
// Bench for reset_seq: default instance plus a minimal-parameter instance,
// both driven by the same stimulus and checked against an edge-count model.
module tb_reset_seq;

  localparam int SA = 2, NA = 4, HA = 16, GA = 4;
  localparam int SB = 3, NB = 1, HB = 1,  GB = 1;

  logic          clk = 1'b0;
  logic          rstb = 1'b0;
  logic          sw_rst = 1'b0;
  logic [NA-1:0] ch_a;
  logic          done_a, busy_a;
  logic [NB-1:0] ch_b;
  logic          done_b, busy_b;

  reset_seq #(.SYNC_STAGES(SA), .NUM_CH(NA), .HOLD_CYCLES(HA), .GAP_CYCLES(GA)) dut_a (
    .clk(clk), .rstb(rstb), .sw_rst(sw_rst), .ch_rstb(ch_a), .done(done_a), .busy(busy_a));

  reset_seq #(.SYNC_STAGES(SB), .NUM_CH(NB), .HOLD_CYCLES(HB), .GAP_CYCLES(GB)) dut_b (
    .clk(clk), .rstb(rstb), .sw_rst(sw_rst), .ch_rstb(ch_b), .done(done_b), .busy(busy_b));

  always #5 clk = ~clk;

  typedef struct {
    int  ch_a;
    bit  done_a;
    int  ch_b;
    bit  done_b;
    string tag;
  } exp_t;

  exp_t q[$];
  event async_ev;
  int   checks = 0;
  int   fails  = 0;

  // Model state: edges since rstb release, and the edge from which hold timing counts.
  int e = 0;
  int anchor_a = 0;
  int anchor_b = 0;
  bit rst_low = 1'b1;

  function automatic int n_rel(int edge_n, int anchor, int hold, int gap, int nch);
    int n = 0;
    for (int k = 0; k < nch; k++)
      if (edge_n >= anchor + hold + k * gap) n++;
    return n;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // One clock cycle of stimulus; pushes the expectation for the coming edge.
  task automatic cycle(input bit sw, input bit async_now, input bit release_now, input string tag);
    exp_t x;
    int na, nb;
    @(negedge clk);
    sw_rst = sw;
    if (release_now) begin
      rstb = 1'b1;
      rst_low = 1'b0;
      e = 0;
      anchor_a = SA;
      anchor_b = SB;
    end
    if (async_now) begin
      #2;
      x = '{0, 1'b0, 0, 1'b0, {tag, "_async"}};
      q.push_back(x);
      rstb = 1'b0;
      rst_low = 1'b1;
      ->async_ev;
    end
    if (rst_low) begin
      x = '{0, 1'b0, 0, 1'b0, tag};
    end else begin
      e++;
      // The first edge in which the FSM sits outside RESET is SYNC_STAGES+2.
      if (sw && e >= SA + 2) anchor_a = e;
      if (sw && e >= SB + 2) anchor_b = e;
      na = n_rel(e, anchor_a, HA, GA, NA);
      nb = n_rel(e, anchor_b, HB, GB, NB);
      x = '{(1 << na) - 1, na == NA, (1 << nb) - 1, nb == NB, tag};
    end
    q.push_back(x);
  endtask

  // Monitor: compares on every active edge and on every asynchronous reset event.
  initial begin
    exp_t x;
    int c;
    forever begin
      @(posedge clk or async_ev);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        check({x.tag, "_ch_a"},   int'(ch_a),   x.ch_a);
        check({x.tag, "_done_a"}, int'(done_a), int'(x.done_a));
        check({x.tag, "_busy_a"}, int'(busy_a), int'(!x.done_a));
        check({x.tag, "_ch_b"},   int'(ch_b),   x.ch_b);
        check({x.tag, "_done_b"}, int'(done_b), int'(x.done_b));
        check({x.tag, "_busy_b"}, int'(busy_b), int'(!x.done_b));
        c = int'(ch_a);
        check({x.tag, "_therm_a"}, int'(((c + 1) & c) == 0), 1);
      end
    end
  end

  initial begin
    int hold_low;
    bit sw, as;
    // Power-on with sw_rst held during RESET, then a one-cycle pulse at edge 40.
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b0, "por_low");
    cycle(1'b1, 1'b0, 1'b1, "por");
    for (int i = 2; i <= 75; i++) cycle(i <= 2 || i == 40, 1'b0, 1'b0, "por_pulse");
    // sw_rst held over edges 40..45.
    cycle(1'b0, 1'b1, 1'b0, "rst2");
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, "rst2_low");
    cycle(1'b0, 1'b0, 1'b1, "held");
    for (int i = 2; i <= 80; i++) cycle(i >= 40 && i <= 45, 1'b0, 1'b0, "held");
    // Asynchronous assertion between edges 24 and 25, then a full restart.
    cycle(1'b0, 1'b1, 1'b0, "rst3");
    cycle(1'b0, 1'b0, 1'b1, "mid");
    for (int i = 2; i <= 24; i++) cycle(1'b0, 1'b0, 1'b0, "mid");
    cycle(1'b0, 1'b1, 1'b0, "mid_async");
    for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0, 1'b0, "mid_low");
    cycle(1'b0, 1'b0, 1'b1, "mid_restart");
    for (int i = 2; i <= 35; i++) cycle(1'b0, 1'b0, 1'b0, "mid_restart");
    // Randomized traffic.
    hold_low = 0;
    for (int i = 0; i < 1500; i++) begin
      if (rst_low) begin
        if (hold_low > 0) begin
          hold_low--;
          cycle($urandom_range(0, 1) == 1, 1'b0, 1'b0, "rnd_low");
        end else begin
          cycle($urandom_range(0, 1) == 1, 1'b0, 1'b1, "rnd_rel");
        end
      end else begin
        sw = ($urandom_range(0, 29) == 0);
        as = ($urandom_range(0, 119) == 0);
        if (as) hold_low = $urandom_range(0, 3);
        cycle(sw, as, 1'b0, "rnd");
      end
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, "tail");
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    check("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
